// File: rtl/jtframe_ioctl_packer.sv
// Packs byte-wide ioctl download strobes into 16-bit masked words, buffers them
// in a small FIFO and drains them to the SDRAM programming port (we/rdy handshake).
module jtframe_ioctl_packer #(
  parameter int unsigned AW         = 25,
  parameter int unsigned SDRAM_AW   = 22,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ioctl_download,
  input  logic                ioctl_wr,
  input  logic [AW-1:0]       ioctl_addr,
  input  logic [7:0]          ioctl_dout,
  output logic [SDRAM_AW-1:0] prog_addr,
  output logic [15:0]         prog_data,
  output logic [1:0]          prog_mask,
  output logic                prog_we,
  input  logic                prog_rdy,
  output logic                downloading,
  output logic                dwnld_done,
  output logic                overflow
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_FLUSH, ST_DRAIN, ST_DONE} state_t;

  state_t              r_state;
  logic                r_dl_prev;
  logic                r_downloading;
  logic                r_done;
  logic                r_overflow;

  logic [SDRAM_AW-1:0] r_hold_addr;
  logic [15:0]         r_hold_data;
  logic [1:0]          r_hold_vld;

  logic [SDRAM_AW-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [15:0]         r_fifo_data [FIFO_DEPTH];
  logic [1:0]          r_fifo_mask [FIFO_DEPTH];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [PW:0]         r_count;

  logic                r_we;
  logic [SDRAM_AW-1:0] r_prog_addr;
  logic [15:0]         r_prog_data;
  logic [1:0]          r_prog_mask;

  logic                w_dl_rise;
  logic                w_take;
  logic [SDRAM_AW-1:0] w_waddr;
  logic [1:0]          w_lane_bit;
  logic [15:0]         w_merged;
  logic                w_pop;
  logic                w_can_push;
  logic                w_push;
  logic                w_push_ok;
  logic [SDRAM_AW-1:0] w_push_addr;
  logic [15:0]         w_push_data;
  logic [1:0]          w_push_mask;
  logic                w_ovf_set;
  logic [SDRAM_AW-1:0] w_hold_addr_nxt;
  logic [15:0]         w_hold_data_nxt;
  logic [1:0]          w_hold_vld_nxt;
  logic                w_unused_addr_hi;

  assign w_dl_rise        = ioctl_download && !r_dl_prev;
  // Bytes are taken in LOAD, and also in the very cycle a download (re)starts.
  assign w_take           = ioctl_wr && ((r_state == ST_LOAD) ||
                            (((r_state == ST_IDLE) || (r_state == ST_DRAIN)) && w_dl_rise));
  assign w_waddr          = ioctl_addr[SDRAM_AW:1];
  assign w_unused_addr_hi = ^ioctl_addr[AW-1:SDRAM_AW+1] ^ ioctl_addr[0];
  assign w_lane_bit       = ioctl_addr[0] ? 2'b10 : 2'b01;
  assign w_merged         = ioctl_addr[0] ? {ioctl_dout, r_hold_data[7:0]}
                                          : {r_hold_data[15:8], ioctl_dout};
  assign w_pop            = r_we && prog_rdy;
  assign w_can_push       = (r_count != (PW+1)'(FIFO_DEPTH)) || w_pop;
  assign w_push_ok        = w_push && w_can_push;

  always_comb begin
    w_push          = 1'b0;
    w_push_addr     = r_hold_addr;
    w_push_data     = r_hold_data;
    w_push_mask     = ~r_hold_vld;   // active-low mask is simply the inverted valid bits
    w_ovf_set       = 1'b0;
    w_hold_addr_nxt = r_hold_addr;
    w_hold_data_nxt = r_hold_data;
    w_hold_vld_nxt  = r_hold_vld;
    if (w_take) begin
      if (r_hold_vld == '0) begin
        w_hold_addr_nxt = w_waddr;
        w_hold_data_nxt = w_merged;
        w_hold_vld_nxt  = w_lane_bit;
      end else if (r_hold_addr == w_waddr) begin
        if ((r_hold_vld | w_lane_bit) == 2'b11) begin
          w_push      = 1'b1;
          w_push_data = w_merged;
          w_push_mask = 2'b00;
          if (w_can_push) w_hold_vld_nxt = '0;
          else            w_ovf_set      = 1'b1;
        end else begin
          w_hold_data_nxt = w_merged;
          w_hold_vld_nxt  = r_hold_vld | w_lane_bit;
        end
      end else begin
        w_push = 1'b1;
        if (w_can_push) begin
          w_hold_addr_nxt = w_waddr;
          w_hold_data_nxt = w_merged;
          w_hold_vld_nxt  = w_lane_bit;
        end else begin
          w_ovf_set = 1'b1;
        end
      end
    end else if ((r_state == ST_FLUSH) && (r_hold_vld != '0)) begin
      w_push = 1'b1;
      if (w_can_push) w_hold_vld_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_fifo_addr[r_wr_ptr] <= w_push_addr;
      r_fifo_data[r_wr_ptr] <= w_push_data;
      r_fifo_mask[r_wr_ptr] <= w_push_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_addr <= '0;
      r_hold_data <= '0;
      r_hold_vld  <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_we        <= 1'b0;
      r_prog_addr <= '0;
      r_prog_data <= '0;
      r_prog_mask <= 2'b11;
    end else begin
      r_hold_addr <= w_hold_addr_nxt;
      r_hold_data <= w_hold_data_nxt;
      r_hold_vld  <= w_hold_vld_nxt;
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_count <= r_count + (PW+1)'(w_push_ok) - (PW+1)'(w_pop);
      // Head is only presented from the registered count, which forces the one-cycle gap.
      if (r_we) begin
        if (prog_rdy) begin
          r_we     <= 1'b0;
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
      end else if (r_count != '0) begin
        r_we        <= 1'b1;
        r_prog_addr <= r_fifo_addr[r_rd_ptr];
        r_prog_data <= r_fifo_data[r_rd_ptr];
        r_prog_mask <= r_fifo_mask[r_rd_ptr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_dl_prev     <= 1'b0;
      r_downloading <= 1'b0;
      r_done        <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_dl_prev <= ioctl_download;
      r_done    <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_dl_rise) begin
          r_state       <= ST_LOAD;
          r_downloading <= 1'b1;
          r_overflow    <= 1'b0;
        end
        ST_LOAD:  if (!ioctl_download) r_state <= ST_FLUSH;
        ST_FLUSH: if ((r_hold_vld == '0) || w_can_push) r_state <= ST_DRAIN;
        ST_DRAIN: begin
          if (w_dl_rise) begin
            r_state <= ST_LOAD;
          end else if ((r_count == '0) && !r_we) begin
            r_state       <= ST_DONE;
            r_done        <= 1'b1;
            r_downloading <= 1'b0;
          end
        end
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
      if (w_ovf_set) r_overflow <= 1'b1;
    end
  end

  assign prog_addr   = r_prog_addr;
  assign prog_data   = r_prog_data;
  assign prog_mask   = r_prog_mask;
  assign prog_we     = r_we;
  assign downloading = r_downloading;
  assign dwnld_done  = r_done;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_jtframe_ioctl_packer.sv
// Scoreboard bench for jtframe_ioctl_packer: directed downloads push expected
// SDRAM writes into a queue; a negedge monitor pops and compares each accepted write.
module tb_jtframe_ioctl_packer;
  localparam int AW  = 25;
  localparam int SAW = 22;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           ioctl_download = 1'b0;
  logic           ioctl_wr = 1'b0;
  logic [AW-1:0]  ioctl_addr = '0;
  logic [7:0]     ioctl_dout = '0;
  logic [SAW-1:0] prog_addr;
  logic [15:0]    prog_data;
  logic [1:0]     prog_mask;
  logic           prog_we;
  logic           prog_rdy = 1'b0;
  logic           downloading;
  logic           dwnld_done;
  logic           overflow;

  jtframe_ioctl_packer #(.AW(AW), .SDRAM_AW(SAW), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .prog_addr      (prog_addr),
    .prog_data      (prog_data),
    .prog_mask      (prog_mask),
    .prog_we        (prog_we),
    .prog_rdy       (prog_rdy),
    .downloading    (downloading),
    .dwnld_done     (dwnld_done),
    .overflow       (overflow)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [SAW-1:0] a;
    logic [15:0]    d;
    logic [1:0]     m;
    logic [15:0]    care;
  } exp_t;
  exp_t q[$];

  task automatic expect_wr(input logic [SAW-1:0] a, input logic [15:0] d,
                           input logic [1:0] m, input logic [15:0] care);
    exp_t e;
    e.a = a; e.d = d; e.m = m; e.care = care;
    q.push_back(e);
  endtask

  // prog_rdy responder: hold low, tie high, or answer rdy_delay cycles after prog_we rises
  logic rdy_hold = 1'b0;
  logic rdy_tie  = 1'b0;
  int   rdy_delay = 0;
  int   rdy_cnt   = 0;
  initial forever begin
    @(posedge clk); #1;
    if (rdy_hold) begin
      prog_rdy = 1'b0; rdy_cnt = 0;
    end else if (rdy_tie) begin
      prog_rdy = 1'b1;
    end else if (prog_we) begin
      if (rdy_cnt >= rdy_delay) begin prog_rdy = 1'b1; rdy_cnt = 0; end
      else begin prog_rdy = 1'b0; rdy_cnt++; end
    end else begin
      prog_rdy = 1'b0; rdy_cnt = 0;
    end
  end

  int cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  int             done_cnt = 0, ack_edge = -1, done_edge = -1, we_len = 0, last_we_len = 0;
  logic           prev_we = 1'b0, prev_acc = 1'b0, prev_done = 1'b0;
  logic [SAW-1:0] prev_a;
  logic [15:0]    prev_d;
  logic [1:0]     prev_m;

  initial forever begin : mon
    exp_t e;
    @(negedge clk);
    if (rst_n) begin
      if (prev_acc) chk("gap_we_low", 32'(prog_we), 0);
      if (prog_we && prev_we && !prev_acc) begin
        chk("stable_addr", 32'(prog_addr), 32'(prev_a));
        chk("stable_data", 32'(prog_data), 32'(prev_d));
        chk("stable_mask", 32'(prog_mask), 32'(prev_m));
      end
      if (prog_we) we_len++;
      else         we_len = 0;
      if (prog_we && prog_rdy) begin
        if (q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL unexpected_write: actual addr=%0h data=%0h mask=%0b required none",
                   prog_addr, prog_data, prog_mask);
        end else begin
          e = q.pop_front();
          chk("wr_addr", 32'(prog_addr), 32'(e.a));
          chk("wr_data", 32'(prog_data & e.care), 32'(e.d & e.care));
          chk("wr_mask", 32'(prog_mask), 32'(e.m));
        end
        ack_edge    = cyc + 1;
        last_we_len = we_len;
        we_len      = 0;
        prev_acc    = 1'b1;
      end else begin
        prev_acc = 1'b0;
      end
      if (dwnld_done) begin
        done_cnt++;
        done_edge = cyc;
        chk("downloading_low_at_done", 32'(downloading), 0);
        chk("done_one_cycle", 32'(prev_done), 0);
      end
      prev_done = dwnld_done;
      prev_we   = prog_we;
      prev_a    = prog_addr;
      prev_d    = prog_data;
      prev_m    = prog_mask;
    end else begin
      prev_we = 1'b0; prev_acc = 1'b0; prev_done = 1'b0; we_len = 0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic put_byte(input logic [AW-1:0] a, input logic [7:0] d);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_done(input int n0, input int budget);
    for (int i = 0; i < budget && done_cnt == n0; i++) tick();
    chk("dwnld_done_seen", 32'(done_cnt), 32'(n0 + 1));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_prog_we"},     32'(prog_we), 0);
    chk({tag, "_prog_mask"},   32'(prog_mask), 32'h3);
    chk({tag, "_prog_addr"},   32'(prog_addr), 0);
    chk({tag, "_prog_data"},   32'(prog_data), 0);
    chk({tag, "_downloading"}, 32'(downloading), 0);
    chk({tag, "_dwnld_done"},  32'(dwnld_done), 0);
    chk({tag, "_overflow"},    32'(overflow), 0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // Paired bytes, prog_rdy tied high; byte strobed in the cycle download rises
    rdy_tie = 1'b1;
    n0 = done_cnt;
    expect_wr(22'd0, 16'h2211, 2'b00, 16'hFFFF);
    chk("downloading_before", 32'(downloading), 0);
    ioctl_download = 1'b1;
    put_byte(25'd0, 8'h11);
    chk("downloading_rise", 32'(downloading), 1);
    put_byte(25'd1, 8'h22);
    chk("latency_we_low", 32'(prog_we), 0);
    ioctl_download = 1'b0;
    tick();
    chk("latency_we_high", 32'(prog_we), 1);
    wait_done(n0, 50);
    chk("done_after_ack", 32'(done_edge - ack_edge), 1);
    chk("downloading_after_done", 32'(downloading), 0);
    rdy_tie = 1'b0;
    repeat (3) tick();

    // Odd length: trailing byte flushed as a low-only partial word
    n0 = done_cnt;
    expect_wr(22'd0, 16'h2211, 2'b00, 16'hFFFF);
    expect_wr(22'd1, 16'h0033, 2'b10, 16'h00FF);
    ioctl_download = 1'b1;
    put_byte(25'd0, 8'h11);
    put_byte(25'd1, 8'h22);
    put_byte(25'd2, 8'h33);
    ioctl_download = 1'b0;
    wait_done(n0, 50);
    repeat (3) tick();

    // Address jump, same-lane overwrite, truncated high address bits,
    // and a byte strobed in the cycle download falls
    n0 = done_cnt;
    expect_wr(22'd2, 16'hAA00, 2'b01, 16'hFF00);
    expect_wr(22'd4, 16'h00BB, 2'b10, 16'h00FF);
    expect_wr(22'd8, 16'h3020, 2'b00, 16'hFFFF);
    expect_wr(22'd3, 16'h8877, 2'b00, 16'hFFFF);
    ioctl_download = 1'b1;
    put_byte(25'd5,  8'hAA);
    put_byte(25'd8,  8'hBB);
    put_byte(25'h10, 8'h10);
    put_byte(25'h10, 8'h20);
    put_byte(25'h11, 8'h30);
    put_byte(25'h1800006, 8'h77);
    ioctl_download = 1'b0;
    put_byte(25'd7, 8'h88);
    wait_done(n0, 80);
    chk("no_overflow_jump", 32'(overflow), 0);
    repeat (3) tick();

    // Backpressure: 12 bytes into a 4-deep FIFO with prog_rdy held low
    rdy_hold = 1'b1;
    n0 = done_cnt;
    for (int k = 0; k < 4; k++)
      expect_wr(22'(32'h10 + k), {8'(32'hC1 + 2*k), 8'(32'hC0 + 2*k)}, 2'b00, 16'hFFFF);
    expect_wr(22'h14, 16'h00C8, 2'b10, 16'h00FF);
    ioctl_download = 1'b1;
    for (int i = 0; i < 12; i++) put_byte(25'(32'h20 + i), 8'(32'hC0 + i));
    chk("overflow_set", 32'(overflow), 1);
    ioctl_download = 1'b0;
    repeat (10) tick();
    chk("overflow_held", 32'(overflow), 1);
    chk("downloading_stalled", 32'(downloading), 1);
    chk("no_done_stalled", 32'(done_cnt), 32'(n0));
    chk("we_stalled", 32'(prog_we), 1);
    rdy_hold = 1'b0;
    wait_done(n0, 100);
    chk("overflow_sticky", 32'(overflow), 1);
    repeat (3) tick();

    // Handshake: prog_rdy answers 5 cycles after prog_we
    rdy_delay = 5;
    n0 = done_cnt;
    expect_wr(22'h20, 16'hA55A, 2'b00, 16'hFFFF);
    expect_wr(22'h21, 16'hC33C, 2'b00, 16'hFFFF);
    ioctl_download = 1'b1;
    put_byte(25'h40, 8'h5A);
    chk("overflow_cleared", 32'(overflow), 0);
    put_byte(25'h41, 8'hA5);
    put_byte(25'h42, 8'h3C);
    put_byte(25'h43, 8'hC3);
    ioctl_download = 1'b0;
    wait_done(n0, 200);
    chk("we_hold_len", 32'(last_we_len), 6);
    rdy_delay = 0;
    repeat (3) tick();

    // Reset mid-download: queued word and hold are discarded
    rdy_hold = 1'b1;
    n0 = done_cnt;
    ioctl_download = 1'b1;
    put_byte(25'd0, 8'h11);
    put_byte(25'd1, 8'h22);
    put_byte(25'd2, 8'h33);
    rst_n = 1'b0;
    ioctl_download = 1'b0;
    tick();
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    rdy_hold = 1'b0;
    repeat (20) tick();
    chk("midrst_no_done", 32'(done_cnt), 32'(n0));
    chk("midrst_we_idle", 32'(prog_we), 0);
    chk("midrst_downloading", 32'(downloading), 0);

    chk("queue_empty", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/jtframe_ioctl_packer.md
# jtframe_ioctl_packer

Downstream stage of the SPI download receiver. It takes the byte-wide `ioctl_*` write strobes produced during a ROM download, packs byte pairs into 16-bit words with byte masks, and buffers them in a small FIFO. It drains the FIFO to the SDRAM programming port using a we/rdy handshake, then signals when the download has been fully committed to memory.

## Interface

**Parameters**
- `AW`, 25: width of `ioctl_addr` (byte address).
- `SDRAM_AW`, 22: width of `prog_addr` (16-bit word address).
- `FIFO_DEPTH`, 4: FIFO depth in words; must be a power of two and at least 2.

**Ports**
- `clk` in 1: system clock; same clock as the receiver's `clk_rom`.
- `rst_n` in 1: asynchronous, active-low reset.
- `ioctl_download` in 1: high while a download is active.
- `ioctl_wr` in 1: single-cycle byte strobe.
- `ioctl_addr` in AW: byte address, valid when `ioctl_wr`=1.
- `ioctl_dout` in 8: byte data, valid when `ioctl_wr`=1.
- `prog_addr` out SDRAM_AW: word address presented with `prog_we`.
- `prog_data` out 16: word data; low byte is the even address.
- `prog_mask` out 2: active-low byte enables. Bit 0 is the low byte, bit 1 is the high byte.
- `prog_we` out 1: write request; held until acknowledged.
- `prog_rdy` in 1: acknowledge, sampled while `prog_we`=1.
- `downloading` out 1: high from download start until the last word is acknowledged.
- `dwnld_done` out 1: one-cycle pulse when the download is fully written.
- `overflow` out 1: sticky flag; a byte was dropped because the FIFO was full.

## Operation

**Reset values:** all outputs are 0, except `prog_mask`=2'b11. The hold register is empty, the FIFO is empty, and the FSM is in IDLE.

**Hold register:** one 16-bit data word, a word address (`ioctl_addr[SDRAM_AW:1]`) and 2 byte-valid bits. On each accepted `ioctl_wr`:
- **Hold empty:** load the byte into the lane selected by `ioctl_addr[0]` and set that valid bit.
- **Hold non-empty, same word address:** merge the byte into its lane. If both lanes are now valid, push the word with mask 2'b00 and empty the hold.
- **Hold non-empty, different word address:** push the hold as a partial word, then load the new byte.
  - Mask is 2'b10 if only the low byte is valid, 2'b01 if only the high byte is valid.
- **Same lane written twice at the same word address:** the new byte overwrites the old one; no push.
- **Address width:** `ioctl_addr` bits above SDRAM_AW are ignored (truncated).

**FIFO:**
- Entries hold {addr, data, mask}.
- A push is accepted if occupancy < FIFO_DEPTH, or if a pop happens in the same cycle.
- If a push is refused, the byte that caused it is dropped, `overflow` is set and the hold is left unchanged.
- `overflow` clears only on the next download start.

**Write port:**
- The FIFO head drives `prog_addr`, `prog_data` and `prog_mask`.
- `prog_we`=1 when the FIFO is non-empty and the port is not in its gap cycle.
- On `prog_rdy`=1 with `prog_we`=1, the head is popped and `prog_we` goes to 0 for exactly one cycle (the gap).
- Outputs are stable while `prog_we`=1.
- `prog_rdy` while `prog_we`=0 is ignored.

**FSM:**
- **IDLE:** on rising `ioctl_download`, clear `overflow` and go to LOAD. `downloading` goes high.
- **LOAD:** accept bytes. When `ioctl_download` falls, go to FLUSH.
- **FLUSH:** push the hold if it is non-empty (retry until accepted), then go to DRAIN.
- **DRAIN:** wait for FIFO empty and `prog_we`=0, then go to DONE.
  - If `ioctl_download` rises again while in DRAIN, return to LOAD. FIFO contents are kept and no done pulse is issued.
- **DONE:** `dwnld_done`=1 for one cycle, `downloading`=0, then go to IDLE.

**Other rules:**
- `ioctl_wr` is ignored outside LOAD, except when it arrives in the same cycle `ioctl_download` rises, in which case it is processed.
- An `ioctl_wr` in the cycle `ioctl_download` falls is processed before FLUSH.
- Asserting `rst_n` low mid-download discards the FIFO and hold. No `dwnld_done` is produced.

## Timing

- All inputs are sampled on the rising edge of `clk`; all outputs are registered.
- `downloading` rises 1 cycle after `ioctl_download` is first sampled high.
- Latency from the strobe that completes a word to `prog_we`=1 is 2 cycles when the FIFO is empty and the port is idle (push registered, then head presented).
- Minimum write period is 2 cycles per word (request, then gap) when `prog_rdy` returns immediately.
- `dwnld_done` follows the final acknowledge by 2 cycles: DRAIN sees empty, then the DONE cycle.
- Back-to-back `ioctl_wr` on consecutive cycles is supported.

## Test plan

- **Paired bytes:** download bytes 0x11@0 and 0x22@1, with `prog_rdy` tied high.
  - Expect one write: addr 0, data 0x2211, mask 2'b00.
  - Expect `dwnld_done` pulse; `downloading` falls with it.
- **Odd length:** bytes 0x11@0, 0x22@1, 0x33@2, then `ioctl_download` falls.
  - Expect second write: addr 1, data 0x??33, mask 2'b10.
- **Address jump:** 0xAA@5 then 0xBB@8.
  - Expect addr 2 data 0xAA?? mask 2'b01, then addr 4 data 0x??BB mask 2'b10.
- **Backpressure:** FIFO_DEPTH=4, `prog_rdy` held 0, stream 12 consecutive bytes (6 words).
  - Expect 4 words queued, `overflow`=1, and the first 4 words written correctly once `prog_rdy` is released.
  - Expect `overflow` cleared at the next download start.
- **Handshake:** `prog_rdy` delayed 5 cycles.
  - Expect `prog_we` and the data held stable for those 5 cycles, a one-cycle gap, then the next word.
- **Reset mid-download:** pulse `rst_n` low after 3 bytes.
  - Expect all outputs at reset values, no write issued and no `dwnld_done`.
